bf_stage_par: RTL and testbench
===============================

BF_STAGE_PAR -- requirements
Module: bf_stage_par

Interface
REQ-001 SHALL provide parameter DATA_W, default 9, input sample width per real/imag component (signed).
REQ-002 SHALL provide parameter LANES, default 16, number of complex samples accepted per valid beat.
REQ-003 SHALL provide parameter DEPTH, default 16, number of beats in each half-frame (delay-buffer depth), legal range 2..256.
REQ-004 SHALL derive OUT_W = DATA_W+1 and CNT_W = clog2(DEPTH), both not overridable.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port din_valid  input  1  beat qualifier for din_i/din_q/din_sync.
REQ-008 SHALL have port din_sync  input  1  frame restart; when sampled with din_valid, that beat is beat 0.
REQ-009 SHALL have port din_i / din_q  input  LANES x DATA_W signed  real/imag lanes.
REQ-010 SHALL have port dout_valid  output  1  butterfly result qualifier.
REQ-011 SHALL have port dout_last  output  1  high with the final result beat of a frame.
REQ-012 SHALL have port dout_add_r / dout_add_i / dout_sub_r / dout_sub_i  output  LANES x OUT_W signed  butterfly sum and difference per lane.
REQ-013 SHALL have port phase  output  1  0 = FILL, 1 = BFLY (current FSM state).

Function
REQ-014 SHALL advance the beat counter only on cycles with din_valid=1; din_valid=0 cycles stall everything, with no state change.
REQ-015 SHALL implement FSM states FILL and BFLY; FILL->BFLY on the valid beat with counter=DEPTH-1; BFLY->FILL on the valid beat with counter=DEPTH-1; counter wraps to 0 at each transition.
REQ-016 SHALL in FILL write each valid beat (all lanes, i and q) into a DEPTH-entry delay buffer in arrival order.
REQ-017 SHALL in BFLY pair beat k with buffered FILL beat k: add = buf + din, sub = buf - din, per lane and per component.
REQ-018 SHALL register results: dout_valid rises exactly 1 cycle after each BFLY valid beat and is low otherwise.
REQ-019 SHALL hold all dout_* data registers at their last value when dout_valid=0.
REQ-020 SHALL without scaling compute sums in OUT_W bits exactly, with no overflow possible.
REQ-021 SHALL assert dout_last together with dout_valid for the result of BFLY beat DEPTH-1 only.
REQ-022 SHALL on a valid beat with din_sync=1, in either state, force state FILL, treat that beat as FILL beat 0, and discard any partial frame; the next result is from the new frame.
REQ-023 SHALL ignore din_sync when din_valid=0.
REQ-024 SHALL accept back-to-back frames at full rate: BFLY beat DEPTH-1 followed immediately by the FILL beat 0 of the next frame, with no bubble required.

Reset
REQ-025 SHALL on rst=1 at a clock edge set state FILL, counter 0, dout_valid 0, dout_last 0, phase 0, and all dout_* data to 0.
REQ-026 SHALL need no reset of delay-buffer contents; buffer contents are never emitted before being rewritten.
REQ-027 SHALL give rst priority over din_valid/din_sync in the same cycle, and abandon a frame that is in progress when rst is asserted.

Configuration
REQ-028 SHALL, when macro BF_STAGE_SCALE_EN is defined, output (x+1)>>>1 for every add/sub result x, computed in DATA_W+2 bits and sign-extended into OUT_W (round-half-up, 1/2 stage scaling).
REQ-029 SHALL, when BF_STAGE_SCALE_EN is undefined, output unscaled results per REQ-020; latency and handshake are identical in both builds.

Verification
REQ-030 SHALL cover basic frame (DEPTH=4, LANES=2): FILL lanes 10,20,30,40, BFLY lanes 1,2,3,4 -> add 11,22,33,44 and sub 9,18,27,36, dout_valid for 4 cycles, dout_last on the 4th.
REQ-031 SHALL cover extremes: buf=255 with din=-256 -> add=-1, sub=511; buf=-256 with din=-256 -> add=-512, sub=0; with BF_STAGE_SCALE_EN -> sub=256, add=-256.
REQ-032 SHALL cover stalls: din_valid toggling 1,0,0,1 throughout a frame -> results identical to REQ-030, each dout_valid exactly 1 cycle after its BFLY beat.
REQ-033 SHALL cover resync: din_sync on BFLY beat 2 -> no further dout_valid until a fresh FILL of 4 beats plus the following BFLY beats; phase returns to 0 on that beat.
REQ-034 SHALL cover reset mid-BFLY: rst=1 for 1 cycle -> next cycle dout_valid=0, phase=0, outputs 0; the next frame processes correctly.
REQ-035 SHALL cover back-to-back frames: 3 consecutive frames with no gaps -> 12 result beats, dout_last on result beats 4, 8 and 12.

Source files
------------

// File: rtl/bf_stage_par.sv
// Radix-2 butterfly stage: first half-frame is buffered, second half-frame is paired lane-wise -> add/sub.
// Latency: one cycle from each BFLY valid beat to its registered dout_valid result.
// Backpressure: none; din_valid=0 stalls all state. Optional macro BF_STAGE_SCALE_EN enables 1/2 rounding scaling.
module bf_stage_par #(
  parameter  int DATA_W = 9,
  parameter  int LANES  = 16,
  parameter  int DEPTH  = 16,
  localparam int OUT_W  = DATA_W + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      din_valid,
  input  logic                      din_sync,
  input  logic [LANES*DATA_W-1:0]   din_i,
  input  logic [LANES*DATA_W-1:0]   din_q,
  output logic                      dout_valid,
  output logic                      dout_last,
  output logic [LANES*OUT_W-1:0]    dout_add_r,
  output logic [LANES*OUT_W-1:0]    dout_add_i,
  output logic [LANES*OUT_W-1:0]    dout_sub_r,
  output logic [LANES*OUT_W-1:0]    dout_sub_i,
  output logic                      phase
);

  // Beat counter width; DEPTH is at least 2, so this is always >= 1.
  localparam int CNT_W  = $clog2(DEPTH);
  // One buffered beat holds every lane of both components: {q lanes, i lanes}.
  localparam int BEAT_W = 2 * LANES * DATA_W;
  localparam int QOFS   = LANES * DATA_W;

  // Frame phase encoding; the value is also what the phase port shows.
  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_BFLY = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       wr_addr;
  logic                   cnt_at_end;
  logic                   fill_wr;
  logic                   bfly_beat;

  // Half-frame delay buffer. Never reset: a slot is always rewritten in FILL
  // before the BFLY half of the same frame reads it back.
  logic [BEAT_W-1:0]      dly_mem [DEPTH];
  logic [BEAT_W-1:0]      dly_rd;

  logic [LANES*OUT_W-1:0] add_r_d, add_i_d, sub_r_d, sub_i_d;

  logic                   dout_valid_q;
  logic                   dout_last_q;
  logic [LANES*OUT_W-1:0] add_r_q, add_i_q, sub_r_q, sub_i_q;

  // Sign-extend one input component to the output width so that sums and
  // differences of two extremes can never wrap.
  function automatic logic [OUT_W-1:0] sx(input logic [DATA_W-1:0] x);
    return {x[DATA_W-1], x};
  endfunction

  // Optional 1/2 scaling with round-half-up: (x+1)>>>1 evaluated one bit
  // wider than the result so the +1 cannot overflow. Taking bits [OUT_W:1]
  // of the widened sum is the arithmetic shift already truncated to OUT_W;
  // the scaled range always fits back into OUT_W bits.
  function automatic logic [OUT_W-1:0] scale_fn(input logic [OUT_W-1:0] x);
`ifdef BF_STAGE_SCALE_EN
    return OUT_W'(({x[OUT_W-1], x} + (OUT_W+1)'(1)) >> 1);
`else
    return x;
`endif
  endfunction

  // Frame sequencing: pick the next phase/counter and classify the current beat.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_addr    = cnt_q;
    fill_wr    = 1'b0;
    bfly_beat  = 1'b0;
    cnt_at_end = (cnt_q == CNT_W'(DEPTH - 1));
    if (din_valid) begin
      if (din_sync) begin
        // Frame restart: this beat is FILL beat 0 whatever was in flight.
        state_d = ST_FILL;
        cnt_d   = CNT_W'(1);
        wr_addr = '0;
        fill_wr = 1'b1;
      end else if (state_q == ST_FILL) begin
        fill_wr = 1'b1;
        if (cnt_at_end) begin
          state_d = ST_BFLY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        bfly_beat = 1'b1;
        if (cnt_at_end) begin
          // Last pairing beat; the next valid beat opens a new frame's FILL.
          state_d = ST_FILL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Capture FILL beats in arrival order; reset suppresses the write so an
  // abandoned frame does not touch the buffer.
  always_ff @(posedge clk) begin
    if (fill_wr && !rst) begin
      dly_mem[wr_addr] <= {din_q, din_i};
    end
  end

  // In BFLY the counter addresses the FILL beat with the same index.
  assign dly_rd = dly_mem[cnt_q];

  // Per-lane butterfly: add = buffered + incoming, sub = buffered - incoming.
  always_comb begin
    add_r_d = '0;
    add_i_d = '0;
    sub_r_d = '0;
    sub_i_d = '0;
    for (int l = 0; l < LANES; l++) begin
      add_r_d[l*OUT_W +: OUT_W] = scale_fn(sx(dly_rd[l*DATA_W +: DATA_W])
                                         + sx(din_i[l*DATA_W +: DATA_W]));
      sub_r_d[l*OUT_W +: OUT_W] = scale_fn(sx(dly_rd[l*DATA_W +: DATA_W])
                                         - sx(din_i[l*DATA_W +: DATA_W]));
      add_i_d[l*OUT_W +: OUT_W] = scale_fn(sx(dly_rd[QOFS + l*DATA_W +: DATA_W])
                                         + sx(din_q[l*DATA_W +: DATA_W]));
      sub_i_d[l*OUT_W +: OUT_W] = scale_fn(sx(dly_rd[QOFS + l*DATA_W +: DATA_W])
                                         - sx(din_q[l*DATA_W +: DATA_W]));
    end
  end

  // Phase/counter state and registered results; data only moves on BFLY beats
  // so it holds its last value while dout_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FILL;
      cnt_q        <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      add_r_q      <= '0;
      add_i_q      <= '0;
      sub_r_q      <= '0;
      sub_i_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dout_valid_q <= bfly_beat;
      dout_last_q  <= bfly_beat & cnt_at_end;
      if (bfly_beat) begin
        add_r_q <= add_r_d;
        add_i_q <= add_i_d;
        sub_r_q <= sub_r_d;
        sub_i_q <= sub_i_d;
      end
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign dout_add_r = add_r_q;
  assign dout_add_i = add_i_q;
  assign dout_sub_r = sub_r_q;
  assign dout_sub_i = sub_i_q;
  assign phase      = state_q;

endmodule

// File: tb/tb_bf_stage_par.sv
// Bench for bf_stage_par (DEPTH=4, LANES=2): directed frames, per-cycle model compare,
// plus literal expectations for the basic, extreme, stall, resync, reset and back-to-back cases.
module tb_bf_stage_par;

  localparam int DW = 9;
  localparam int LN = 2;
  localparam int DP = 4;
  localparam int OW = DW + 1;

  logic              clk;
  logic              rst;
  logic              din_valid;
  logic              din_sync;
  logic [LN*DW-1:0]  din_i;
  logic [LN*DW-1:0]  din_q;
  logic              dout_valid;
  logic              dout_last;
  logic [LN*OW-1:0]  dout_add_r;
  logic [LN*OW-1:0]  dout_add_i;
  logic [LN*OW-1:0]  dout_sub_r;
  logic [LN*OW-1:0]  dout_sub_i;
  logic              phase;

  int n_checks = 0;
  int n_fail   = 0;

  // Results captured on every dout_valid cycle, for literal checks.
  logic [LN*OW-1:0] q_add_r[$];
  logic [LN*OW-1:0] q_sub_r[$];
  bit               q_last[$];

  int exp_add[4];
  int exp_sub[4];

  bf_stage_par #(.DATA_W(DW), .LANES(LN), .DEPTH(DP)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din_sync   (din_sync),
    .din_i      (din_i),
    .din_q      (din_q),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .dout_add_r (dout_add_r),
    .dout_add_i (dout_add_i),
    .dout_sub_r (dout_sub_r),
    .dout_sub_i (dout_sub_i),
    .phase      (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int in_lane(input logic [LN*DW-1:0] v, input int l);
    logic signed [DW-1:0] t;
    t = v[l*DW +: DW];
    return int'(t);
  endfunction

  function automatic int out_lane(input logic [LN*OW-1:0] v, input int l);
    logic signed [OW-1:0] t;
    t = v[l*OW +: OW];
    return int'(t);
  endfunction

  function automatic int scl(input int x);
`ifdef BF_STAGE_SCALE_EN
    return (x + 1) >>> 1;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a frame is 2*DP valid beats; the first DP are stored,
  // beat DP+k pairs with stored beat k. Checked one edge after each input.
  int  m_pos;
  int  m_fr[DP][LN];
  int  m_fq[DP][LN];
  int  e_add_r[LN], e_add_i[LN], e_sub_r[LN], e_sub_i[LN];
  bit  e_vld, e_last, e_phase;

  initial begin
    m_pos = 0;
    e_vld = 0; e_last = 0; e_phase = 0;
    for (int l = 0; l < LN; l++) begin
      e_add_r[l] = 0; e_add_i[l] = 0; e_sub_r[l] = 0; e_sub_i[l] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        m_pos = 0; e_vld = 0; e_last = 0;
        for (int l = 0; l < LN; l++) begin
          e_add_r[l] = 0; e_add_i[l] = 0; e_sub_r[l] = 0; e_sub_i[l] = 0;
        end
      end else if (din_valid) begin
        if (din_sync) m_pos = 0;
        if (m_pos < DP) begin
          for (int l = 0; l < LN; l++) begin
            m_fr[m_pos][l] = in_lane(din_i, l);
            m_fq[m_pos][l] = in_lane(din_q, l);
          end
          e_vld = 0; e_last = 0;
        end else begin
          for (int l = 0; l < LN; l++) begin
            e_add_r[l] = scl(m_fr[m_pos-DP][l] + in_lane(din_i, l));
            e_sub_r[l] = scl(m_fr[m_pos-DP][l] - in_lane(din_i, l));
            e_add_i[l] = scl(m_fq[m_pos-DP][l] + in_lane(din_q, l));
            e_sub_i[l] = scl(m_fq[m_pos-DP][l] - in_lane(din_q, l));
          end
          e_vld  = 1;
          e_last = (m_pos == 2*DP - 1);
        end
        m_pos = (m_pos + 1) % (2*DP);
      end else begin
        e_vld = 0; e_last = 0;
      end
      e_phase = (m_pos >= DP);

      chk("dout_valid", int'(dout_valid), int'(e_vld));
      chk("dout_last", int'(dout_last), int'(e_last));
      chk("phase", int'(phase), int'(e_phase));
      for (int l = 0; l < LN; l++) begin
        chk($sformatf("add_r[%0d]", l), out_lane(dout_add_r, l), e_add_r[l]);
        chk($sformatf("add_i[%0d]", l), out_lane(dout_add_i, l), e_add_i[l]);
        chk($sformatf("sub_r[%0d]", l), out_lane(dout_sub_r, l), e_sub_r[l]);
        chk($sformatf("sub_i[%0d]", l), out_lane(dout_sub_i, l), e_sub_i[l]);
      end
      if (dout_valid) begin
        q_add_r.push_back(dout_add_r);
        q_sub_r.push_back(dout_sub_r);
        q_last.push_back(dout_last);
      end
    end
  end

  // Drivers: called at a falling edge, return at the next falling edge.
  task automatic beat(input bit s, input int r0, input int r1, input int i0, input int i1);
    din_valid = 1'b1;
    din_sync  = s;
    din_i     = {DW'(r1), DW'(r0)};
    din_q     = {DW'(i1), DW'(i0)};
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit s);
    din_valid = 1'b0;
    din_sync  = s;
    din_i     = (LN*DW)'($urandom);
    din_q     = (LN*DW)'($urandom);
    repeat (n) @(negedge clk);
    din_sync  = 1'b0;
  endtask

  task automatic frame_basic(input int gap);
    for (int k = 0; k < DP; k++) begin
      beat(1'b0, 10*(k+1), 10*(k+1), -10*(k+1), 7);
      if (gap > 0) idle(gap, 1'b1);
    end
    for (int k = 0; k < DP; k++) begin
      beat(1'b0, k+1, k+1, k+1, -3);
      if (gap > 0) idle(gap, 1'b1);
    end
  endtask

  task automatic check_basic(input string nm, input int base);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_add%0d", nm, i), out_lane(q_add_r[base+i], 0), exp_add[i]);
      chk($sformatf("%s_sub%0d", nm, i), out_lane(q_sub_r[base+i], 0), exp_sub[i]);
      chk($sformatf("%s_last%0d", nm, i), int'(q_last[base+i]), (i == 3) ? 1 : 0);
    end
  endtask

  function automatic void clear_q();
    q_add_r.delete();
    q_sub_r.delete();
    q_last.delete();
  endfunction

  initial begin
`ifdef BF_STAGE_SCALE_EN
    exp_add = '{6, 11, 17, 22};
    exp_sub = '{5, 9, 14, 18};
`else
    exp_add = '{11, 22, 33, 44};
    exp_sub = '{9, 18, 27, 36};
`endif
    rst = 1'b1; din_valid = 1'b0; din_sync = 1'b0; din_i = '0; din_q = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_last", int'(dout_last), 0);
    chk("rst_phase", int'(phase), 0);
    chk("rst_add_r0", out_lane(dout_add_r, 0), 0);
    rst = 1'b0;

    // Basic frame
    clear_q();
    frame_basic(0);
    idle(2, 1'b0);
    chk("basic_count", q_add_r.size(), 4);
    check_basic("basic", 0);

    // Extremes
    clear_q();
    for (int k = 0; k < DP; k++) beat(1'b0, 255, -256, 0, 0);
    for (int k = 0; k < DP; k++) beat(1'b0, -256, -256, 0, 0);
    idle(2, 1'b0);
    chk("ext_count", q_add_r.size(), 4);
`ifdef BF_STAGE_SCALE_EN
    chk("ext_add0", out_lane(q_add_r[0], 0), 0);
    chk("ext_sub0", out_lane(q_sub_r[0], 0), 256);
    chk("ext_add1", out_lane(q_add_r[0], 1), -256);
    chk("ext_sub1", out_lane(q_sub_r[0], 1), 0);
`else
    chk("ext_add0", out_lane(q_add_r[0], 0), -1);
    chk("ext_sub0", out_lane(q_sub_r[0], 0), 511);
    chk("ext_add1", out_lane(q_add_r[0], 1), -512);
    chk("ext_sub1", out_lane(q_sub_r[0], 1), 0);
`endif

    // Stalls: valid pattern 1,0,0 with sync asserted on the idle cycles
    clear_q();
    frame_basic(2);
    idle(2, 1'b0);
    chk("stall_count", q_add_r.size(), 4);
    check_basic("stall", 0);

    // Resync on BFLY beat 2
    clear_q();
    for (int k = 0; k < DP; k++) beat(1'b0, 50+k, 60+k, 0, 0);
    beat(1'b0, 1, 1, 0, 0);
    beat(1'b0, 2, 2, 0, 0);
    beat(1'b1, 100, 100, 0, 0);
    chk("resync_phase", int'(phase), 0);
    chk("resync_valid", int'(dout_valid), 0);
    for (int k = 1; k < DP; k++) beat(1'b0, 100+k, 100+k, 0, 0);
    chk("resync_count_mid", q_add_r.size(), 2);
    for (int k = 0; k < DP; k++) beat(1'b0, 5, 5, 0, 0);
    idle(2, 1'b0);
    chk("resync_count", q_add_r.size(), 6);
`ifdef BF_STAGE_SCALE_EN
    chk("resync_add", out_lane(q_add_r[2], 0), 53);
`else
    chk("resync_add", out_lane(q_add_r[2], 0), 105);
`endif

    // Reset mid-BFLY, with a valid beat presented during reset
    clear_q();
    for (int k = 0; k < DP; k++) beat(1'b0, 70, 70, 1, 1);
    beat(1'b0, 9, 9, 9, 9);
    beat(1'b0, 9, 9, 9, 9);
    rst = 1'b1;
    din_valid = 1'b1;
    din_sync  = 1'b0;
    @(negedge clk);
    chk("midrst_valid", int'(dout_valid), 0);
    chk("midrst_phase", int'(phase), 0);
    chk("midrst_add_r0", out_lane(dout_add_r, 0), 0);
    chk("midrst_sub_r1", out_lane(dout_sub_r, 1), 0);
    rst = 1'b0;
    frame_basic(0);
    idle(2, 1'b0);
    chk("midrst_count", q_add_r.size(), 6);
    check_basic("midrst", 2);

    // Back-to-back frames
    clear_q();
    frame_basic(0);
    frame_basic(0);
    frame_basic(0);
    idle(2, 1'b0);
    chk("b2b_count", q_add_r.size(), 12);
    for (int f = 0; f < 3; f++) check_basic($sformatf("b2b%0d", f), 4*f);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
